// File: rtl/lcd1602_ctrl_if.sv
// Host byte port of the HD44780 controller: one command/data byte per req_valid&&req_ready.
// init_done and busy report controller status back to the host.
interface lcd1602_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;
    logic       init_done;
    logic       busy;

    modport master (
        output req_valid, req_rs, req_data,
        input  req_ready, init_done, busy
    );

    modport slave (
        input  req_valid, req_rs, req_data,
        output req_ready, init_done, busy
    );
endinterface

// File: rtl/lcd1602_ctrl.sv
// HD44780 16x2 write-only controller: power-up wait, fixed init, then one host byte at a time.
// Bus valid one cycle after accept; req_ready held low for SETUP+PULSE+HOLD+WAIT, nothing is queued.
module lcd1602_ctrl #(
    parameter int unsigned T_PWR  = 750000,
    parameter int unsigned T_SU   = 4,
    parameter int unsigned T_EN   = 25,
    parameter int unsigned T_HD   = 4,
    parameter int unsigned T_EXEC = 2000,
    parameter int unsigned T_CLR  = 80000
) (
    input  logic          clk,
    input  logic          rst_n,
    lcd1602_ctrl_if.slave host,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_en,
    output logic [7:0]    lcd_dat,
    output logic          lcd_n,
    output logic          lcd_p
);

    localparam int unsigned M0    = (T_PWR > T_SU)   ? T_PWR : T_SU;
    localparam int unsigned M1    = (M0 > T_EN)      ? M0    : T_EN;
    localparam int unsigned M2    = (M1 > T_HD)      ? M1    : T_HD;
    localparam int unsigned M3    = (M2 > T_EXEC)    ? M2    : T_EXEC;
    localparam int unsigned T_MAX = (M3 > T_CLR)     ? M3    : T_CLR;
    localparam int          CW    = $clog2(T_MAX) + 1;

    typedef logic [CW-1:0] cnt_t;

    // Each phase loads T-1 so that it lasts exactly T cycles before the zero test fires.
    localparam cnt_t LD_PWR  = cnt_t'(T_PWR  - 1);
    localparam cnt_t LD_SU   = cnt_t'(T_SU   - 1);
    localparam cnt_t LD_EN   = cnt_t'(T_EN   - 1);
    localparam cnt_t LD_HD   = cnt_t'(T_HD   - 1);
    localparam cnt_t LD_EXEC = cnt_t'(T_EXEC - 1);
    localparam cnt_t LD_CLR  = cnt_t'(T_CLR  - 1);

    typedef enum logic [2:0] {
        ST_PWR,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } state_t;

    state_t     state_q, state_nxt;
    cnt_t       cnt_q,   cnt_nxt;
    logic [1:0] idx_q,   idx_nxt;
    logic       rs_q,    rs_nxt;
    logic [7:0] dat_q,   dat_nxt;
    logic       en_q,    en_nxt;
    logic       rdy_q,   rdy_nxt;
    logic       done_q,  done_nxt;
    logic       cnt_zero;
    logic       is_clr;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = 8'h38;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h06;
            default: b = 8'h01;
        endcase
        return b;
    endfunction

    assign cnt_zero = (cnt_q == '0);
    // Clear and return-home need the long execution wait; selection uses the byte on the bus.
    assign is_clr   = !rs_q && ((dat_q == 8'h01) || (dat_q == 8'h02) || (dat_q == 8'h03));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PWR;
            cnt_q   <= LD_PWR;
            idx_q   <= 2'd0;
            rs_q    <= 1'b0;
            dat_q   <= 8'h00;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            idx_q   <= idx_nxt;
            rs_q    <= rs_nxt;
            dat_q   <= dat_nxt;
            en_q    <= en_nxt;
            rdy_q   <= rdy_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_zero ? cnt_q : cnt_q - cnt_t'(1);
        idx_nxt   = idx_q;
        rs_nxt    = rs_q;
        dat_nxt   = dat_q;
        en_nxt    = en_q;
        rdy_nxt   = rdy_q;
        done_nxt  = done_q;

        case (state_q)
            ST_PWR: begin
                if (cnt_zero) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = LD_SU;
                    idx_nxt   = 2'd0;
                    rs_nxt    = 1'b0;
                    dat_nxt   = init_byte(2'd0);
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = LD_EN;
                    en_nxt    = 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = LD_HD;
                    en_nxt    = 1'b0;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = is_clr ? LD_CLR : LD_EXEC;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    // During init, chain straight into the next ROM byte.
                    if (!done_q && (idx_q != 2'd3)) begin
                        state_nxt = ST_SETUP;
                        cnt_nxt   = LD_SU;
                        idx_nxt   = idx_q + 2'd1;
                        rs_nxt    = 1'b0;
                        dat_nxt   = init_byte(idx_q + 2'd1);
                    end else begin
                        state_nxt = ST_IDLE;
                        rdy_nxt   = 1'b1;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (host.req_valid && rdy_q) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = LD_SU;
                    rs_nxt    = host.req_rs;
                    dat_nxt   = host.req_data;
                    rdy_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_PWR;
                cnt_nxt   = LD_PWR;
                en_nxt    = 1'b0;
                rdy_nxt   = 1'b0;
            end
        endcase
    end

    assign lcd_rs         = rs_q;
    assign lcd_rw         = 1'b0;
    assign lcd_en         = en_q;
    assign lcd_dat        = dat_q;
    assign lcd_n          = 1'b0;
    assign lcd_p          = 1'b1;
    assign host.req_ready = rdy_q;
    assign host.busy      = ~rdy_q;
    assign host.init_done = done_q;

    // E and ready are pure functions of the phase; init_done never falls outside reset.
    a_en_in_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        en_q == (state_q == ST_PULSE));
    a_rdy_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
        rdy_q == (state_q == ST_IDLE));
    a_done_sticky: assert property (@(posedge clk) disable iff (!rst_n)
        done_q |=> done_q);

endmodule
